// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, NOP encoding, register index width.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned REM_W     = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW compare of a producer rd against the consumer's rs1/rs2; x0 never matches.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 rd_valid,
    output logic                 hazard_c
);

    always_comb begin
        hazard_c = rd_valid && (rd != '0) &&
                   ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / control hazard controller for the IF/ID and ID/EX latches, with Mealy outputs.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL     = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] ID_rs1,
    input  logic [REG_IDX_W-1:0] ID_rs2,
    input  logic                 ID_rs1_used,
    input  logic                 ID_rs2_used,
    input  logic [REG_IDX_W-1:0] EX_rd,
    input  logic                 EX_mem_read,
    input  logic                 EX_branch_taken,
    input  logic                 mem_busy,
    output logic                 PC_EN,
    output logic                 IF_ID_EN,
    output logic                 IF_ID_stall,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_bubble,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [REM_W-1:0] LU_RELOAD = REM_W'(LU_STALL - 1);
    localparam logic [REM_W-1:0] FL_RELOAD = REM_W'(FLUSH_CYCLES - 1);

    hz_state_e        state, state_nxt;
    logic [REM_W-1:0] cnt, cnt_nxt;
    logic             load_use_c;

    hazard_detect u_hazard_detect (
        .rs1      (ID_rs1),
        .rs2      (ID_rs2),
        .rs1_used (ID_rs1_used),
        .rs2_used (ID_rs2_used),
        .rd       (EX_rd),
        .rd_valid (EX_mem_read),
        .hazard_c (load_use_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Priority: mem_busy freeze, taken branch, residual FLUSH/STALL, fresh load-use.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        PC_EN        = 1'b1;
        IF_ID_EN     = 1'b1;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;

        if (!rst) begin
            if (mem_busy) begin
                PC_EN    = 1'b0;
                IF_ID_EN = 1'b0;
            end else if (EX_branch_taken) begin
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FL_RELOAD;
                end else begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end else begin
                case (state)
                    FLUSH: begin
                        // ID instruction is wrong-path here, so load-use is ignored.
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                        if (cnt > REM_W'(1)) begin
                            cnt_nxt = cnt - REM_W'(1);
                        end else begin
                            state_nxt = RUN;
                            cnt_nxt   = '0;
                        end
                    end
                    STALL: begin
                        PC_EN        = 1'b0;
                        IF_ID_stall  = 1'b1;
                        ID_EX_bubble = 1'b1;
                        if (cnt > REM_W'(1)) begin
                            cnt_nxt = cnt - REM_W'(1);
                        end else if (load_use_c && (LU_STALL > 1)) begin
                            cnt_nxt = LU_RELOAD;
                        end else begin
                            state_nxt = RUN;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        if (load_use_c) begin
                            PC_EN        = 1'b0;
                            IF_ID_stall  = 1'b1;
                            ID_EX_bubble = 1'b1;
                            if (LU_STALL > 1) begin
                                state_nxt = STALL;
                                cnt_nxt   = LU_RELOAD;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters; mem_busy already forces stall/flush low, the explicit gate keeps the intent clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_busy) begin
            if (IF_ID_stall) stall_cnt <= stall_cnt + CNT_W'(1);
            if (IF_ID_flush) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameter sets driven in lockstep and checked against
// a remaining-cycles reference model; counters checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int unsigned NCFG = 3;
    localparam int unsigned CW   = 8;

    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_BUSY  = 5'b00000;
    localparam logic [4:0] O_FLUSH = 5'b11011;
    localparam logic [4:0] O_STALL = 5'b01101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, ex_mem_read = 1'b0;
    logic       br_taken = 1'b0, mem_busy = 1'b0;

    logic [4:0]    obs [NCFG];
    logic [CW-1:0] sc  [NCFG];
    logic [CW-1:0] fc  [NCFG];

    int lu_p [NCFG] = '{1, 3, 2};
    int fl_p [NCFG] = '{2, 2, 1};

    int          stall_left [NCFG];
    int          flush_left [NCFG];
    int unsigned m_sc [NCFG];
    int unsigned m_fc [NCFG];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL(1), .FLUSH_CYCLES(2), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2),
        .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .EX_rd(ex_rd),
        .EX_mem_read(ex_mem_read), .EX_branch_taken(br_taken), .mem_busy(mem_busy),
        .PC_EN(obs[0][4]), .IF_ID_EN(obs[0][3]), .IF_ID_stall(obs[0][2]),
        .IF_ID_flush(obs[0][1]), .ID_EX_bubble(obs[0][0]),
        .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    pipe_hazard_ctrl #(.LU_STALL(3), .FLUSH_CYCLES(2), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2),
        .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .EX_rd(ex_rd),
        .EX_mem_read(ex_mem_read), .EX_branch_taken(br_taken), .mem_busy(mem_busy),
        .PC_EN(obs[1][4]), .IF_ID_EN(obs[1][3]), .IF_ID_stall(obs[1][2]),
        .IF_ID_flush(obs[1][1]), .ID_EX_bubble(obs[1][0]),
        .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    pipe_hazard_ctrl #(.LU_STALL(2), .FLUSH_CYCLES(1), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2),
        .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .EX_rd(ex_rd),
        .EX_mem_read(ex_mem_read), .EX_branch_taken(br_taken), .mem_busy(mem_busy),
        .PC_EN(obs[2][4]), .IF_ID_EN(obs[2][3]), .IF_ID_stall(obs[2][2]),
        .IF_ID_flush(obs[2][1]), .ID_EX_bubble(obs[2][0]),
        .stall_cnt(sc[2]), .flush_cnt(fc[2])
    );

    // One cycle: drive inputs, predict outputs from remaining-cycle counts, compare, advance model.
    task automatic step(input logic r, input logic mb, input logic br, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2);
        logic          lu;
        logic [4:0]    exp_o;
        logic [CW-1:0] exp_sc, exp_fc;
        @(negedge clk);
        rst = r; mem_busy = mb; br_taken = br; ex_mem_read = mr;
        ex_rd = rd; id_rs1 = r1; id_rs2 = r2; rs1_used = u1; rs2_used = u2;
        #1;
        lu = mr && (rd != 5'd0) && ((u1 && rd == r1) || (u2 && rd == r2));
        for (int k = 0; k < int'(NCFG); k++) begin
`ifdef HAZARD_PERF_CNT_EN
            exp_sc = CW'(m_sc[k]);
            exp_fc = CW'(m_fc[k]);
`else
            exp_sc = '0;
            exp_fc = '0;
`endif
            n_cmp++;
            assert (sc[k] === exp_sc) else begin
                n_fail++;
                $error("FAIL stall_cnt[%0d] observed=%0d expected=%0d", k, sc[k], exp_sc);
            end
            n_cmp++;
            assert (fc[k] === exp_fc) else begin
                n_fail++;
                $error("FAIL flush_cnt[%0d] observed=%0d expected=%0d", k, fc[k], exp_fc);
            end

            if (r) begin
                stall_left[k] = 0;
                flush_left[k] = 0;
                m_sc[k] = 0;
                m_fc[k] = 0;
                continue;
            end

            if (mb) begin
                exp_o = O_BUSY;
            end else if (br) begin
                exp_o = O_FLUSH;
                stall_left[k] = 0;
                flush_left[k] = fl_p[k] - 1;
            end else if (flush_left[k] > 0) begin
                exp_o = O_FLUSH;
                flush_left[k]--;
            end else if (stall_left[k] > 0) begin
                exp_o = O_STALL;
                if (stall_left[k] == 1 && lu) stall_left[k] = lu_p[k] - 1;
                else stall_left[k]--;
            end else if (lu) begin
                exp_o = O_STALL;
                stall_left[k] = lu_p[k] - 1;
            end else begin
                exp_o = O_IDLE;
            end

            if (exp_o[2]) m_sc[k]++;
            if (exp_o[1]) m_fc[k]++;

            n_cmp++;
            assert (obs[k] === exp_o) else begin
                n_fail++;
                $error("FAIL ctrl[%0d] {pc,en,stall,flush,bubble} observed=%b expected=%b",
                       k, obs[k], exp_o);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < int'(NCFG); k++) begin
            stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end

        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        n_cmp++;
        assert (obs[0] === O_IDLE) else begin
            n_fail++;
            $error("FAIL reset_idle observed=%b expected=%b", obs[0], O_IDLE);
        end

        // Load-use on rs1, then the same with rd=x0.
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        idle(4);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        idle(1);
        // Load-use on rs2 only, and a match with the used flag clear.
        step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 1);
        idle(3);
        step(0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 0, 0);
        idle(1);

        // Taken branch alone.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(3);

        // Branch in the second stall cycle abandons the stall.
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(3);

        // mem_busy freezes FLUSH with one cycle remaining.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // Load-use held through the stall: re-arm in the final cycle.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 5'd3, 5'd3, 5'd3, 1, 1);
        idle(3);

        // Load-use during FLUSH is ignored.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
        idle(3);

        // Reset in the middle of a stall.
        step(0, 0, 0, 1, 5'd6, 5'd0, 5'd6, 0, 1);
        step(1, 0, 0, 1, 5'd6, 5'd0, 5'd6, 0, 1);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 400) == 0,
                 ($urandom % 100) < 12,
                 ($urandom % 100) < 10,
                 ($urandom % 100) < 45,
                 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                 1'($urandom), 1'($urandom));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
